// File: rtl/io_seq_pkg.sv
// Shared types and defaults for the IO-ring power sequencer.
package io_seq_pkg;

  localparam int IO_SEQ_DEBOUNCE_DEF = 1024;
  localparam int IO_SEQ_STEP_DEF     = 16;

  typedef enum logic [2:0] {
    SEQ_OFF      = 3'd0,
    SEQ_DEBOUNCE = 3'd1,
    SEQ_REL_RET  = 3'd2,
    SEQ_EN_IE    = 3'd3,
    SEQ_EN_OE    = 3'd4,
    SEQ_ON       = 3'd5,
    SEQ_DIS_OE   = 3'd6,
    SEQ_DIS_IE   = 3'd7
  } io_seq_state_e;

  function automatic int io_seq_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/io_seq_sync.sv
// Two-flop synchronizer with asynchronous active-low reset to 0.
module io_seq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/io_ring_pwr_seq.sv
// VDDX/VSSX pad-ring power sequencer: debounce, ordered enable/disable, brownout safe state.
// Optional brownout event counter (bo_clr/bo_count) enabled by macro IO_SEQ_BROWNOUT_CNT_EN.
module io_ring_pwr_seq
  import io_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYC = IO_SEQ_DEBOUNCE_DEF,
  parameter int STEP_CYC     = IO_SEQ_STEP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vddio_ok_a,
  input  logic       pwr_req,
  output logic       pwr_ack,
  output logic       pad_ret_n,
  output logic       pad_ie,
  output logic       pad_oe,
  output logic [2:0] seq_state,
  output logic       brownout
`ifdef IO_SEQ_BROWNOUT_CNT_EN
  ,
  input  logic       bo_clr,
  output logic [7:0] bo_count
`endif
);

  localparam int CNT_W = $clog2(io_seq_max(DEBOUNCE_CYC, STEP_CYC) + 1);

  io_seq_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brownout_q, brownout_d;
  logic             ok_s;
  logic             deb_done, step_done, counting;

  io_seq_sync #(.WIDTH(1)) u_ok_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (vddio_ok_a),
    .q_o    (ok_s)
  );

  assign deb_done  = (cnt_q == CNT_W'(DEBOUNCE_CYC - 1));
  assign step_done = (cnt_q == CNT_W'(STEP_CYC - 1));
  // ON is the only powered state without a timed exit, so it must not count.
  assign counting  = !(state_q inside {SEQ_OFF, SEQ_ON});

  always_comb begin
    state_d    = state_q;
    brownout_d = 1'b0;
    case (state_q)
      SEQ_OFF:      if (pwr_req && ok_s) state_d = SEQ_DEBOUNCE;
      SEQ_DEBOUNCE: begin
        if (!ok_s || !pwr_req) state_d = SEQ_OFF;
        else if (deb_done)     state_d = SEQ_REL_RET;
      end
      SEQ_REL_RET: begin
        if (!pwr_req)       state_d = SEQ_DIS_OE;
        else if (step_done) state_d = SEQ_EN_IE;
      end
      SEQ_EN_IE: begin
        if (!pwr_req)       state_d = SEQ_DIS_OE;
        else if (step_done) state_d = SEQ_EN_OE;
      end
      SEQ_EN_OE: begin
        if (!pwr_req)       state_d = SEQ_DIS_OE;
        else if (step_done) state_d = SEQ_ON;
      end
      SEQ_ON:       if (!pwr_req) state_d = SEQ_DIS_OE;
      SEQ_DIS_OE:   if (step_done) state_d = SEQ_DIS_IE;
      SEQ_DIS_IE:   if (step_done) state_d = SEQ_OFF;
    endcase

    // Supply loss overrides every other transition once pads may be released.
    if (!ok_s && !(state_q inside {SEQ_OFF, SEQ_DEBOUNCE})) begin
      state_d    = SEQ_OFF;
      brownout_d = 1'b1;
    end

    if (state_d != state_q) cnt_d = '0;
    else if (counting)      cnt_d = cnt_q + 1'b1;
    else                    cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEQ_OFF;
      cnt_q      <= '0;
      brownout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      brownout_q <= brownout_d;
    end
  end

  assign seq_state = state_q;
  assign pad_ret_n = !(state_q inside {SEQ_OFF, SEQ_DEBOUNCE});
  assign pad_ie    = state_q inside {SEQ_EN_IE, SEQ_EN_OE, SEQ_ON, SEQ_DIS_OE};
  assign pad_oe    = state_q inside {SEQ_EN_OE, SEQ_ON};
  assign pwr_ack   = (state_q == SEQ_ON);
  assign brownout  = brownout_q;

`ifdef IO_SEQ_BROWNOUT_CNT_EN
  logic [7:0] bo_cnt_q, bo_cnt_d;

  always_comb begin
    bo_cnt_d = bo_cnt_q;
    if (bo_clr)                              bo_cnt_d = '0;
    else if (brownout_d && bo_cnt_q != 8'hFF) bo_cnt_d = bo_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bo_cnt_q <= '0;
    else        bo_cnt_q <= bo_cnt_d;
  end

  assign bo_count = bo_cnt_q;
`endif

endmodule
